// File: rtl/keypad_pkg.sv
// Purpose: shared key codes, column drive patterns, scan states and decode helpers for the keypad scanner.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package keypad_pkg;

    // Key codes as seen by the turn-control logic.
    localparam logic [3:0] KEY_NONE   = 4'd0;
    localparam logic [3:0] KEY_P1_END = 4'd3;
    localparam logic [3:0] KEY_P2_END = 4'd1;

    // One-hot active-low column drive.
    localparam logic [2:0] COL0_DRV = 3'b110;
    localparam logic [2:0] COL1_DRV = 3'b101;
    localparam logic [2:0] COL2_DRV = 3'b011;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } state_t;

    function automatic logic [2:0] col_drive(input logic [1:0] idx);
        case (idx)
            2'd1:    return COL1_DRV;
            2'd2:    return COL2_DRV;
            default: return COL0_DRV;
        endcase
    endfunction

    function automatic logic [1:0] next_col(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Code = 3*row + col + 1 for exactly one low row; anything else
    // (idle or ghosting) decodes to KEY_NONE.
    function automatic logic [3:0] key_code(input logic [3:0] row_n, input logic [1:0] col);
        logic [3:0] base;
        case (row_n)
            4'b1110: base = 4'd1;
            4'b1101: base = 4'd4;
            4'b1011: base = 4'd7;
            4'b0111: base = 4'd10;
            default: base = KEY_NONE;
        endcase
        if (base == KEY_NONE) begin
            return KEY_NONE;
        end
        return base + {2'b00, col};
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Purpose: keypad_in bundle between the keypad pins/scanner (master) and the game core (slave).
// Latency: n/a (wires only).
// Backpressure: none; key_valid is a single-cycle strobe the consumer must take when it appears.
// Signals: key_row (row sense, active-low), key_col (column drive, one-hot active-low),
//          keypad_out (key code during pulse), key_valid (press strobe), key_held (key still down).
interface keypad_scan_if;
    logic [3:0] key_row;
    logic [2:0] key_col;
    logic [3:0] keypad_out;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  key_row,
        output key_col,
        output keypad_out,
        output key_valid,
        output key_held
    );

    modport slave (
        output key_row,
        input  key_col,
        input  keypad_out,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/scan_tick.sv
// Purpose: free-running divider, strobes tick on the last cycle of every DIV-cycle slot.
// Latency: tick high on the cycle where the counter equals DIV-1 (counter is 0 right after reset).
// Backpressure: none; free-running.
// Ports: clk, rst (sync active-low), tick (one-cycle strobe every DIV cycles).
module scan_tick #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q;

    assign tick = (cnt_q == W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end
endmodule

// File: rtl/keypad_scan.sv
// Purpose: scans a 4x3 keypad, debounces press and release, emits one code pulse per press.
// Latency: (DEBOUNCE_CNT-1)*SCAN_DIV+1 cycles from the first tick that sees the key to key_valid.
// Backpressure: none; keypad_out/key_valid is a one-cycle registered strobe.
// Ports: clk, rst (sync active-low), kp (keypad_scan_if.master: key_row in; key_col,
//        keypad_out, key_valid, key_held out).
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.master kp
);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    state_t         state_q, state_d;
    logic [1:0]     col_q, col_d;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [3:0]     code_q, code_d;
    logic [3:0]     out_q, out_d;
    logic           vld_q, vld_d;
    logic           tick;
    logic [3:0]     sample;

    scan_tick #(.DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign sample  = key_code(kp.key_row, col_q);
    assign cnt_inc = cnt_q + CW'(1);

    // The same counter serves as press count in DEBOUNCE and as release count in HOLD.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        out_d   = KEY_NONE;
        vld_d   = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (sample != KEY_NONE) begin
                        code_d = sample;
                        if (DEBOUNCE_CNT == 1) begin
                            out_d   = sample;
                            vld_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = HOLD;
                        end else begin
                            cnt_d   = CW'(1);
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        col_d = next_col(col_q);
                    end
                end
                DEBOUNCE: begin
                    if (sample == code_q) begin
                        if (cnt_inc == CW'(DEBOUNCE_CNT)) begin
                            out_d   = code_q;
                            vld_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = HOLD;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // Bounce: rescan from the same column, no output.
                        cnt_d   = '0;
                        state_d = SCAN;
                    end
                end
                HOLD: begin
                    if (kp.key_row == 4'hF) begin
                        if (cnt_inc == CW'(DEBOUNCE_CNT)) begin
                            cnt_d   = '0;
                            col_d   = next_col(col_q);
                            state_d = SCAN;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= SCAN;
            col_q   <= 2'd0;
            cnt_q   <= '0;
            code_q  <= KEY_NONE;
            out_q   <= KEY_NONE;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
        end
    end

    assign kp.key_col    = col_drive(col_q);
    assign kp.keypad_out = out_q;
    assign kp.key_valid  = vld_q;
    assign kp.key_held   = (state_q == HOLD);
endmodule

// File: tb/tb_keypad_scan.sv
// Purpose: self-checking bench for keypad_scan with a keypad matrix model and a tick-level reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_keypad_scan;
    localparam int SCAN_DIV = 4;
    localparam int DB       = 3;
    localparam int M_SCAN   = 0;
    localparam int M_DEB    = 1;
    localparam int M_HOLD   = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    keypad_scan_if kif ();

    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DB)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif)
    );

    // Physical keypad: a pressed key shorts its row to its column.
    bit         pressed [4][3];
    logic       raw_en  = 1'b1;
    logic [3:0] raw_row = 4'b1110;
    logic [3:0] row_drv;

    always_comb begin
        row_drv = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r][c] && !kif.key_col[c]) row_drv[r] = 1'b0;
        if (raw_en) row_drv = raw_row;
    end
    assign kif.key_row = row_drv;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;
    int last_code = 0;

    // Reference: what the keypad should show, evaluated once per slot.
    int m_div = 0, m_col = 0, m_mode = M_SCAN, m_n = 0, m_code = 0, m_pulse = 0;
    int m_pulses = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_rows();
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 4; i++)
            if (pressed[i][m_col]) r[i] = 1'b0;
        if (raw_en) r = raw_row;
        return r;
    endfunction

    task automatic clear_keys();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                pressed[r][c] = 1'b0;
    endtask

    // One clock: evaluate the reference with pre-edge inputs, then compare after the edge.
    task automatic step();
        logic [3:0] rin;
        logic       rs;
        int         lows, ridx, s;
        logic [2:0] exp_col;
        rin = model_rows();
        rs  = rst;
        @(posedge clk);
        if (!rs) begin
            m_div = 0; m_col = 0; m_mode = M_SCAN; m_n = 0; m_code = 0; m_pulse = 0;
        end else begin
            m_pulse = 0;
            if (m_div == SCAN_DIV - 1) begin
                m_div = 0;
                lows = 0; ridx = 0;
                for (int i = 0; i < 4; i++)
                    if (!rin[i]) begin lows++; ridx = i; end
                s = (lows == 1) ? 3 * ridx + m_col + 1 : 0;
                if (m_mode == M_SCAN) begin
                    if (s != 0) begin
                        m_code = s; m_n = 1; m_mode = M_DEB;
                    end else begin
                        m_col = (m_col + 1) % 3;
                    end
                end else if (m_mode == M_DEB) begin
                    if (s == m_code) m_n++;
                    else begin m_n = 0; m_mode = M_SCAN; end
                end else begin
                    if (rin == 4'hF) begin
                        m_n++;
                        if (m_n == DB) begin m_n = 0; m_mode = M_SCAN; m_col = (m_col + 1) % 3; end
                    end else m_n = 0;
                end
                if (m_mode == M_DEB && m_n == DB) begin
                    m_pulse = m_code; m_mode = M_HOLD; m_n = 0; m_pulses++;
                end
            end else begin
                m_div++;
            end
        end
        #1;
        exp_col = ~(3'b001 << m_col);
        chk("key_col",    32'(kif.key_col),    32'(exp_col));
        chk("keypad_out", 32'(kif.keypad_out), 32'(m_pulse));
        chk("key_valid",  32'(kif.key_valid),  32'(m_pulse != 0));
        chk("key_held",   32'(kif.key_held),   32'(m_mode == M_HOLD));
        if (kif.key_valid === 1'b1) begin
            pulses++;
            last_code = int'(kif.keypad_out);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_model(input string tag, input int mode, input int cnt, input int budget);
        int k;
        k = 0;
        while (!(m_mode == mode && (cnt < 0 || m_n == cnt)) && k < budget) begin
            step();
            k++;
        end
        chk(tag, 32'(m_mode == mode), 32'd1);
    endtask

    initial begin
        clear_keys();
        // 1: reset with a row low, then idle rotation
        run(3);
        chk("rst_col", 32'(kif.key_col), 32'h6);
        rst = 1'b1; raw_en = 1'b0; raw_row = 4'hF;
        run(16);

        // 2: steady press row0/col2 -> code 3
        pulses = 0;
        pressed[0][2] = 1'b1;
        wait_model("s2_accept", M_HOLD, -1, 60);
        run(10);
        pressed[0][2] = 1'b0;
        run(20);
        chk("s2_pulses", 32'(pulses), 32'd1);
        chk("s2_code", 32'(last_code), 32'd3);

        // 3: bounce on row0/col0, then a stable press -> code 1
        pulses = 0;
        pressed[0][0] = 1'b1;
        wait_model("s3_detect", M_DEB, 1, 60);
        pressed[0][0] = 1'b0;
        run(16);
        chk("s3_bounce_pulses", 32'(pulses), 32'd0);
        pressed[0][0] = 1'b1;
        wait_model("s3_accept", M_HOLD, -1, 80);
        run(5);
        pressed[0][0] = 1'b0;
        run(20);
        chk("s3_pulses", 32'(pulses), 32'd1);
        chk("s3_code", 32'(last_code), 32'd1);

        // 4: ghosting, two rows low
        pulses = 0;
        raw_en = 1'b1; raw_row = 4'b1100;
        run(20);
        raw_en = 1'b0; raw_row = 4'hF;
        run(4);
        chk("s4_pulses", 32'(pulses), 32'd0);

        // 5: long hold row3/col1 with a second key, release, press again
        pulses = 0;
        pressed[3][1] = 1'b1;
        run(200);
        pressed[2][1] = 1'b1;
        run(40);
        pressed[2][1] = 1'b0;
        run(20);
        chk("s5_hold_pulses", 32'(pulses), 32'd1);
        pressed[3][1] = 1'b0;
        run(30);
        pressed[3][1] = 1'b1;
        run(60);
        pressed[3][1] = 1'b0;
        run(30);
        chk("s5_pulses", 32'(pulses), 32'd2);
        chk("s5_code", 32'(last_code), 32'd11);

        // 6: reset in the middle of debounce
        pulses = 0;
        pressed[1][2] = 1'b1;
        wait_model("s6_deb2", M_DEB, 2, 80);
        rst = 1'b0;
        step();
        chk("s6_rst_col", 32'(kif.key_col), 32'h6);
        chk("s6_rst_held", 32'(kif.key_held), 32'd0);
        rst = 1'b1;
        pressed[1][2] = 1'b0;
        run(30);
        chk("s6_pulses", 32'(pulses), 32'd0);

        // Random presses with optional bounce
        pulses = 0;
        m_pulses = 0;
        for (int it = 0; it < 15; it++) begin
            int r, c;
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                pressed[r][c] = 1'b1;
                run($urandom_range(1, 7));
                pressed[r][c] = 1'b0;
                run($urandom_range(1, 6));
            end
            pressed[r][c] = 1'b1;
            run($urandom_range(20, 80));
            pressed[r][c] = 1'b0;
            run($urandom_range(16, 40));
        end
        chk("rand_pulses", 32'(pulses), 32'(m_pulses));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4-row x 3-column membrane keypad, debounces presses, and emits a 4-bit key code for exactly one cycle per press.
- Its output is the keypad code consumed by the turn-control logic, for example code 4'b0011 ends player 1's turn and 4'b0001 ends player 2's turn.
- It sits between the board keypad pins and the game core. It is the producer side of the keypad_in interface.

Parameters:
- SCAN_DIV, 1000, clock cycles per column slot. Rows are sampled once per slot, on its last cycle. Legal range is 2 or more.
- DEBOUNCE_CNT, 4, number of consecutive identical samples needed to accept a press or a release. Legal range is 1 or more.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; one clock, synchronous, active-low (rst=0 resets on the next posedge clk)
- key_row  input  4  row sense lines, active-low (pulled high); assumed already synchronised
- key_col  output  3  column drive, one-hot active-low; col0=3'b110, col1=3'b101, col2=3'b011
- keypad_out  output  4  key code during a press pulse, 4'b0000 at all other times
- key_valid  output  1  high for exactly one cycle, coincident with a nonzero keypad_out
- key_held  output  1  high while an accepted key is still held down (HOLD state)

Behaviour:
- Reset values:
  - key_col=3'b110, keypad_out=0, key_valid=0, key_held=0.
  - State=SCAN, column index=0, divider=0, debounce/release count=0, captured code=0.
- Reset is honoured in every state. A reset asserted mid-debounce or mid-hold aborts that activity and no pulse is emitted.
- Tick:
  - The divider counts 0..SCAN_DIV-1 and wraps.
  - tick=1 on the cycle where divider==SCAN_DIV-1. All row sampling happens only on tick.
- Code map: a key at row r (0..3) and column c (0..2) has code = 3*r + c + 1, giving 1..12. Code 0 means no key.
- A valid sample has exactly one row low. Zero rows low means idle. Two or more rows low (ghosting) is treated as invalid.
- SCAN state:
  - On tick with a valid sample: capture the code, set count=1, go to DEBOUNCE. The column is frozen.
  - On tick with no valid sample: advance the column 0->1->2->0.
  - If DEBOUNCE_CNT==1, a valid sample goes directly to the accept step below.
- DEBOUNCE state:
  - On tick with a valid sample equal to the captured code: count++.
  - When count reaches DEBOUNCE_CNT, accept the key. In the following cycle keypad_out=code and key_valid=1, and the state becomes HOLD.
  - On tick with any other sample (idle, different row, or invalid): clear count, return to SCAN on the same column, no output.
- Output pulse:
  - keypad_out and key_valid are registered.
  - Both return to 0 on the cycle after the pulse, even if the key is still held.
  - There is never more than one pulse per physical press.
- HOLD state:
  - key_held=1 and the column stays frozen.
  - On tick with all rows high: release count++. On tick with any row low: release count=0.
  - When release count reaches DEBOUNCE_CNT, go to SCAN, advance the column, and drop key_held.
- Press latency, measured from the first tick that sees the key: (DEBOUNCE_CNT-1)*SCAN_DIV+1 cycles to key_valid.
- Boundaries:
  - Divider wrap and column wrap (2->0) are seamless.
  - A second key pressed while in HOLD is ignored until a full release is seen.
  - Bounce during DEBOUNCE restarts scanning and never yields a partial pulse.

Decomposition:
- Shared package (keypad_pkg) holds:
  - the code constants: KEY_NONE=4'd0, KEY_P1_END=4'd3, KEY_P2_END=4'd1;
  - the column drive patterns;
  - the state encoding SCAN/DEBOUNCE/HOLD.
- One sub-module, scan_tick, is the SCAN_DIV divider producing the tick strobe. It is reusable by the display multiplexer.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3):
1. Reset held low for 3 cycles with key_row=4'b1110 -> all outputs at their reset values and key_col=3'b110. After release, key_col rotates 110->101->011->110 every 4 cycles while key_row=4'b1111.
2. Steady press at row0/col2 (key_row=4'b1110 while key_col=3'b011) -> exactly one cycle with keypad_out=4'd3 and key_valid=1, 9 cycles after the first detecting tick. key_held=1 until 3 idle ticks are seen after release.
3. Press at row0/col0 that bounces (idle on the 2nd tick) -> no pulse, scanning resumes. A subsequent stable press -> single pulse with keypad_out=4'd1.
4. Two rows low at once (key_row=4'b1100) for 20 cycles -> no pulse, the column keeps rotating.
5. Hold row3/col1 for 200 cycles, then release and press again -> two pulses with code 4'd11 and none in between. A second key pressed during HOLD produces no pulse.
6. rst=0 asserted during DEBOUNCE (count=2) -> no pulse. Next cycle: reset values and key_col=3'b110.
